// File: rtl/rf_writeback_ctrl_if.sv
// Writeback bundle: ALU and long-latency result handshakes, issue notification,
// and the register bank write port.
interface rf_writeback_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [4:0]        lsu_reg;
  logic [DATA_W-1:0] lsu_data;
  logic              iss_valid;
  logic [4:0]        iss_reg;
  logic              regwrite;
  logic [4:0]        wreg;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output lsu_valid, lsu_reg, lsu_data,
    output iss_valid, iss_reg,
    input  alu_ready, lsu_ready,
    input  regwrite, wreg, WriteData
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  lsu_valid, lsu_reg, lsu_data,
    input  iss_valid, iss_reg,
    output alu_ready, lsu_ready,
    output regwrite, wreg, WriteData
  );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// Merges the single-cycle ALU path and the FIFO-buffered long-latency path onto
// the register bank write port, and tracks in-flight long-latency destinations.
module rf_writeback_ctrl #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rf_writeback_ctrl_if.slave      wb,
  output logic [31:0]             pending,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]        fifo_reg  [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;

  logic              empty, full, starved;
  logic              alu_fire, alu_wr, push, pop;
  logic              vld_p0;
  logic [4:0]        sel_reg_p0;
  logic [DATA_W-1:0] sel_data_p0;
  logic [31:0]       pending_nxt;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign starved = (starve_cnt >= SW'(STARVE_LIMIT));

  assign wb.alu_ready = rst_n && (!starved || empty);
  assign wb.lsu_ready = rst_n && !full;

  // A zero-destination ALU result is consumed but leaves the write slot free.
  assign alu_fire = wb.alu_valid && wb.alu_ready;
  assign alu_wr   = alu_fire && (wb.alu_reg != 5'd0);
  assign pop      = !empty && !alu_wr;
  assign push     = wb.lsu_valid && wb.lsu_ready && (wb.lsu_reg != 5'd0);

  always_comb begin
    vld_p0      = alu_wr || pop;
    sel_reg_p0  = alu_wr ? wb.alu_reg  : fifo_reg[rd_ptr];
    sel_data_p0 = alu_wr ? wb.alu_data : fifo_data[rd_ptr];
  end

  // Issue sets after a pop clears, so a re-issue of the retiring register survives.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[fifo_reg[rd_ptr]] = 1'b0;
    if (wb.iss_valid && (wb.iss_reg != 5'd0)) pending_nxt[wb.iss_reg] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= wb.lsu_reg;
      fifo_data[wr_ptr] <= wb.lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pending    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (empty || pop)  starve_cnt <= '0;
      else if (!starved) starve_cnt <= starve_cnt + 1'b1;
      pending <= pending_nxt;
    end
  end

  // Write port stage: selection made in p0 is presented for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.regwrite  <= 1'b0;
      wb.wreg      <= '0;
      wb.WriteData <= '0;
    end else begin
      wb.regwrite <= vld_p0;
      if (vld_p0) begin
        wb.wreg      <= sel_reg_p0;
        wb.WriteData <= sel_data_p0;
      end
    end
  end

  assign fifo_count = count;
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl: per-source expected-write queues are
// consumed by a write-port monitor, with timed checks at each directed step.
module tb_rf_writeback_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  logic [36:0] q_alu[$];
  logic [36:0] q_lsu[$];

  rf_writeback_ctrl_if #(.DATA_W(32)) bus();

  rf_writeback_ctrl #(.DEPTH(4), .STARVE_LIMIT(8), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (bus),
    .pending    (pending),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_reg = '0; bus.lsu_data = '0;
    bus.iss_valid = 1'b0; bus.iss_reg = '0;
  endtask

  // Every registered write must match the head of one source's expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.regwrite === 1'b1) begin
      logic hit;
      logic [36:0] got;
      got = {bus.wreg, bus.WriteData};
      chk("wreg_nonzero", 64'(bus.wreg != 5'd0), 64'd1);
      hit = 1'b0;
      if (q_alu.size() > 0 && q_alu[0] === got) begin
        void'(q_alu.pop_front());
        hit = 1'b1;
      end else if (q_lsu.size() > 0 && q_lsu[0] === got) begin
        void'(q_lsu.pop_front());
        hit = 1'b1;
      end
      chk("write_expected", 64'(hit), 64'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int run, stalls, n;
    logic stall_now;

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_regwrite",  64'(bus.regwrite),  64'd0);
    chk("rst_wreg",      64'(bus.wreg),      64'd0);
    chk("rst_wdata",     64'(bus.WriteData), 64'd0);
    chk("rst_pending",   64'(pending),       64'd0);
    chk("rst_count",     64'(fifo_count),    64'd0);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single ALU write: one-cycle latency, one-cycle pulse.
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    chk("alu_ready_idle", 64'(bus.alu_ready), 64'd1);
    chk("lsu_ready_idle", 64'(bus.lsu_ready), 64'd1);
    q_alu.push_back({5'd5, 32'hDEADBEEF});
    step();
    idle_inputs();
    chk("t1_regwrite", 64'(bus.regwrite),  64'd1);
    chk("t1_wreg",     64'(bus.wreg),      64'd5);
    chk("t1_wdata",    64'(bus.WriteData), 64'hDEADBEEF);
    step();
    chk("t1_pulse_end", 64'(bus.regwrite), 64'd0);

    // Register-0 results are swallowed on both paths.
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'h1234;
    step();
    idle_inputs();
    chk("t2_alu0_regwrite", 64'(bus.regwrite), 64'd0);
    bus.lsu_valid = 1'b1; bus.lsu_reg = 5'd0; bus.lsu_data = 32'h4321;
    #1;
    chk("t2_lsu0_ready", 64'(bus.lsu_ready), 64'd1);
    step();
    idle_inputs();
    chk("t2_lsu0_count",    64'(fifo_count),   64'd0);
    chk("t2_lsu0_regwrite", 64'(bus.regwrite), 64'd0);
    step();
    chk("t2_after_regwrite", 64'(bus.regwrite), 64'd0);

    // ALU beats the FIFO; the pending bit clears at the long write edge.
    bus.iss_valid = 1'b1; bus.iss_reg = 5'd7;
    step();
    idle_inputs();
    chk("t3_pending_set", 64'(pending[7]), 64'd1);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'hA3;
    bus.lsu_valid = 1'b1; bus.lsu_reg = 5'd7; bus.lsu_data = 32'h55;
    q_alu.push_back({5'd3, 32'hA3});
    q_lsu.push_back({5'd7, 32'h55});
    step();
    idle_inputs();
    chk("t3_first_wreg",  64'(bus.wreg),   64'd3);
    chk("t3_count",       64'(fifo_count), 64'd1);
    chk("t3_pending_mid", 64'(pending[7]), 64'd1);
    step();
    chk("t3_second_wreg",  64'(bus.wreg),      64'd7);
    chk("t3_second_wdata", 64'(bus.WriteData), 64'h55);
    chk("t3_pending_clr",  64'(pending[7]),    64'd0);
    step();
    chk("t3_idle", 64'(bus.regwrite), 64'd0);

    // Starvation: continuous ALU traffic against a full FIFO.
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd20; bus.alu_data = 32'hA4000000;
    bus.lsu_valid = 1'b1; bus.lsu_reg = 5'd10; bus.lsu_data = 32'h5000000A;
    #1;
    chk("t4_alu_ready0", 64'(bus.alu_ready), 64'd1);
    q_alu.push_back({5'd20, 32'hA4000000});
    q_lsu.push_back({5'd10, 32'h5000000A});
    step();
    run = 0; stalls = 0; n = 1;
    for (int k = 0; k < 100 && fifo_count != 3'd0; k++) begin
      bus.alu_data = 32'hA4000000 + 32'(n);
      n++;
      if (k < 3) begin
        bus.lsu_valid = 1'b1; bus.lsu_reg = 5'(11 + k); bus.lsu_data = 32'h5000000B + 32'(k);
      end else begin
        bus.lsu_valid = 1'b0;
      end
      #1;
      if (k < 3) begin
        chk("t4_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        q_lsu.push_back({bus.lsu_reg, bus.lsu_data});
      end
      if (k == 3) begin
        chk("t4_lsu_ready_full", 64'(bus.lsu_ready), 64'd0);
        chk("t4_count_full",     64'(fifo_count),    64'd4);
      end
      stall_now = !bus.alu_ready;
      if (!stall_now) begin
        q_alu.push_back({5'd20, bus.alu_data});
        run++;
      end else begin
        chk("t4_starve_run", 64'(run), 64'd8);
        stalls++;
        run = 0;
      end
      step();
      if (stall_now) chk("t4_stall_pop_reg", 64'(bus.wreg), 64'(10 + stalls - 1));
    end
    chk("t4_drained", 64'(fifo_count), 64'd0);
    chk("t4_stalls",  64'(stalls),     64'd4);
    idle_inputs();
    step();
    step();

    // Pop of reg 9 coincides with a new issue to reg 9: set wins.
    bus.iss_valid = 1'b1; bus.iss_reg = 5'd9;
    step();
    idle_inputs();
    bus.lsu_valid = 1'b1; bus.lsu_reg = 5'd9; bus.lsu_data = 32'h99;
    q_lsu.push_back({5'd9, 32'h99});
    step();
    idle_inputs();
    bus.iss_valid = 1'b1; bus.iss_reg = 5'd9;
    step();
    idle_inputs();
    chk("t5_pop_wreg",    64'(bus.wreg),   64'd9);
    chk("t5_pending_set", 64'(pending[9]), 64'd1);
    step();

    // Mid-cycle reset with three queued long results and live pending bits.
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd21; bus.alu_data = 32'hA6000000 + 32'(k);
      bus.lsu_valid = 1'b1; bus.lsu_reg = 5'(4 + 2 * k); bus.lsu_data = 32'h60000000 + 32'(k);
      bus.iss_valid = 1'b1; bus.iss_reg = 5'(4 + 2 * k);
      if (k < 2) q_alu.push_back({5'd21, bus.alu_data});
      step();
    end
    idle_inputs();
    chk("t6_count_pre",   64'(fifo_count), 64'd3);
    chk("t6_pending_pre", 64'(pending),    64'h350);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_regwrite",  64'(bus.regwrite),  64'd0);
    chk("t6_rst_wreg",      64'(bus.wreg),      64'd0);
    chk("t6_rst_wdata",     64'(bus.WriteData), 64'd0);
    chk("t6_rst_pending",   64'(pending),       64'd0);
    chk("t6_rst_count",     64'(fifo_count),    64'd0);
    chk("t6_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("t6_rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_stale_write", 64'(bus.regwrite), 64'd0);
      chk("t6_count_post",     64'(fifo_count),   64'd0);
    end
    bus.lsu_valid = 1'b1; bus.lsu_reg = 5'd15; bus.lsu_data = 32'h5F;
    q_lsu.push_back({5'd15, 32'h5F});
    step();
    idle_inputs();
    step();
    chk("t6_new_wreg", 64'(bus.wreg), 64'd15);
    step();
    step();

    chk("alu_queue_empty", 64'(q_alu.size()), 64'd0);
    chk("lsu_queue_empty", 64'(q_lsu.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
